// File: rtl/mux_pipe_pkg.sv
// Shared constants and helpers for the mux_pipe operand-select pipeline.
package mux_pipe_pkg;

   localparam int DEFAULT_WIDTH = 32;
   localparam int DEFAULT_N     = 3;

   // Select width for an n-way choice; never narrower than one bit.
   function automatic int sel_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/mux_pipe_if.sv
// Handshaked bus between a producer/consumer pair and mux_pipe.
// Carries the optional sel_err flag when MUX_PIPE_SEL_ERR_EN is defined.
interface mux_pipe_if #(
   parameter int WIDTH = mux_pipe_pkg::DEFAULT_WIDTH,
   parameter int N     = mux_pipe_pkg::DEFAULT_N
);
   import mux_pipe_pkg::*;

   localparam int SW = sel_width(N);

   logic [N*WIDTH-1:0] in_data;
   logic [SW-1:0]      in_sel;
   logic               in_valid;
   logic               in_ready;
   logic               flush;
   logic [WIDTH-1:0]   out_data;
   logic [SW-1:0]      out_sel;
   logic               out_valid;
   logic               out_ready;
`ifdef MUX_PIPE_SEL_ERR_EN
   logic               sel_err;
`endif

   modport master (
      output in_data, in_sel, in_valid, flush, out_ready,
      input  in_ready, out_data, out_sel, out_valid
`ifdef MUX_PIPE_SEL_ERR_EN
      , input sel_err
`endif
   );

   modport slave (
      input  in_data, in_sel, in_valid, flush, out_ready,
      output in_ready, out_data, out_sel, out_valid
`ifdef MUX_PIPE_SEL_ERR_EN
      , output sel_err
`endif
   );

endinterface

// File: rtl/mux_pipe_muxn_comb.sv
// Purely combinational N:1 select; any out-of-range select falls back to channel 0.
module muxn_comb
   import mux_pipe_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int N     = DEFAULT_N
) (
   input  logic [N*WIDTH-1:0]      data,
   input  logic [sel_width(N)-1:0] sel,
   output logic [WIDTH-1:0]        y
);

   always_comb begin
      y = data[WIDTH-1:0];
      for (int k = 1; k < N; k++) begin
         if (int'(sel) == k) begin
            y = data[k*WIDTH +: WIDTH];
         end
      end
   end

endmodule

// File: rtl/mux_pipe.sv
// N-input operand select with a registered output and a 2-entry (main + skid) buffer.
// Optional out-of-range select flag enabled by MUX_PIPE_SEL_ERR_EN.
module mux_pipe
   import mux_pipe_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int N     = DEFAULT_N
) (
   input  logic     clk,
   input  logic     resetn,
   mux_pipe_if.slave bus
);

   localparam int SW = sel_width(N);

   logic [WIDTH-1:0] sel_data;
   logic             accept;
   logic             pop;
   logic             in_ready;
   logic             ready_q;

   logic             m_valid, m_valid_n;
   logic [WIDTH-1:0] m_data,  m_data_n;
   logic [SW-1:0]    m_sel,   m_sel_n;
   logic             s_valid, s_valid_n;
   logic [WIDTH-1:0] s_data,  s_data_n;
   logic [SW-1:0]    s_sel,   s_sel_n;
`ifdef MUX_PIPE_SEL_ERR_EN
   logic             in_err;
   logic             m_err, m_err_n;
   logic             s_err, s_err_n;
`endif

   muxn_comb #(
      .WIDTH (WIDTH),
      .N     (N)
   ) u_muxn (
      .data (bus.in_data),
      .sel  (bus.in_sel),
      .y    (sel_data)
   );

   // ready_q mirrors ~s_valid from a register; resetn only gates it so reset holds producers off.
   assign in_ready      = ready_q & resetn;
   assign accept        = bus.in_valid & in_ready;
   assign pop           = m_valid & bus.out_ready;

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = m_valid;
   assign bus.out_data  = m_data;
   assign bus.out_sel   = m_sel;
`ifdef MUX_PIPE_SEL_ERR_EN
   assign in_err        = (int'(bus.in_sel) >= N);
   assign bus.sel_err   = m_err & m_valid;
`endif

   always_comb begin
      m_valid_n = m_valid;
      m_data_n  = m_data;
      m_sel_n   = m_sel;
      s_valid_n = s_valid;
      s_data_n  = s_data;
      s_sel_n   = s_sel;
`ifdef MUX_PIPE_SEL_ERR_EN
      m_err_n   = m_err;
      s_err_n   = s_err;
`endif
      if (pop && s_valid) begin
         m_data_n  = s_data;
         m_sel_n   = s_sel;
`ifdef MUX_PIPE_SEL_ERR_EN
         m_err_n   = s_err;
`endif
         s_valid_n = 1'b0;
      end else if (pop && !accept) begin
         m_valid_n = 1'b0;
      end

      // A new beat lands in main only if main is (or is about to be) empty with no skid backlog.
      if (accept) begin
         if ((!m_valid || pop) && !s_valid) begin
            m_valid_n = 1'b1;
            m_data_n  = sel_data;
            m_sel_n   = bus.in_sel;
`ifdef MUX_PIPE_SEL_ERR_EN
            m_err_n   = in_err;
`endif
         end else begin
            s_valid_n = 1'b1;
            s_data_n  = sel_data;
            s_sel_n   = bus.in_sel;
`ifdef MUX_PIPE_SEL_ERR_EN
            s_err_n   = in_err;
`endif
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         m_valid <= 1'b0;
         m_data  <= '0;
         m_sel   <= '0;
         s_valid <= 1'b0;
         s_data  <= '0;
         s_sel   <= '0;
         ready_q <= 1'b1;
`ifdef MUX_PIPE_SEL_ERR_EN
         m_err   <= 1'b0;
         s_err   <= 1'b0;
`endif
      end else if (bus.flush) begin
         m_valid <= 1'b0;
         s_valid <= 1'b0;
         ready_q <= 1'b1;
`ifdef MUX_PIPE_SEL_ERR_EN
         m_err   <= 1'b0;
         s_err   <= 1'b0;
`endif
      end else begin
         m_valid <= m_valid_n;
         m_data  <= m_data_n;
         m_sel   <= m_sel_n;
         s_valid <= s_valid_n;
         s_data  <= s_data_n;
         s_sel   <= s_sel_n;
         ready_q <= ~s_valid_n;
`ifdef MUX_PIPE_SEL_ERR_EN
         m_err   <= m_err_n;
         s_err   <= s_err_n;
`endif
      end
   end

endmodule

// File: tb/tb_mux_pipe.sv
// Scoreboard bench for mux_pipe (N=3, WIDTH=32); checks sel_err when MUX_PIPE_SEL_ERR_EN is defined.
module tb_mux_pipe;
   import mux_pipe_pkg::*;

   localparam int WIDTH = 32;
   localparam int N     = 3;

   typedef struct {
      logic [31:0] data;
      logic [1:0]  sel;
      logic        err;
   } beat_t;

   logic clk    = 1'b0;
   logic resetn = 1'b0;
   int   tests  = 0;
   int   fails  = 0;
   int   cycle  = 0;
   beat_t exp_q[$];
   int    pop_cycles[$];

   mux_pipe_if #(.WIDTH(WIDTH), .N(N)) bus ();

   mux_pipe #(.WIDTH(WIDTH), .N(N)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      tests++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   // Monitor: every beat the consumer takes must match the oldest expected beat.
   always @(negedge clk) begin : monitor
      beat_t e;
      if (resetn && bus.out_valid && bus.out_ready) begin
         pop_cycles.push_back(cycle);
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL unexpected_beat: got %0h expected none", bus.out_data);
         end else begin
            e = exp_q.pop_front();
            checkOutput("out_data", bus.out_data, e.data);
            checkOutput("out_sel", {30'b0, bus.out_sel}, {30'b0, e.sel});
`ifdef MUX_PIPE_SEL_ERR_EN
            checkOutput("sel_err", {31'b0, bus.sel_err}, {31'b0, e.err});
`endif
         end
      end
   end

   // Present one beat and hold it until accepted; returns 1ns after the accepting edge.
   task automatic applyStimulus(input logic [1:0] sel, input logic [31:0] exp_data, input logic exp_err);
      bit accepted = 0;
      beat_t e;
      bus.in_sel   = sel;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            accepted = 1;
            break;
         end
      end
      if (!accepted) begin
         tests++;
         fails++;
         $display("[TB] FAIL accept_timeout: got in_ready=0 expected 1 within 50 cycles");
      end else begin
         e.data = exp_data;
         e.sel  = sel;
         e.err  = exp_err;
         exp_q.push_back(e);
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      bus.in_data   = {32'h33, 32'h22, 32'h11};
      bus.in_sel    = 2'd1;
      bus.in_valid  = 1'b1;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b0;

      // Reset held 3 cycles with a pending producer.
      waitCycles(3);
      checkOutput("reset_in_ready", {31'b0, bus.in_ready}, 32'd0);
      checkOutput("reset_out_valid", {31'b0, bus.out_valid}, 32'd0);
      checkOutput("reset_out_data", bus.out_data, 32'h0);
      checkOutput("reset_out_sel", {30'b0, bus.out_sel}, 32'd0);
      resetn       = 1'b1;
      bus.in_valid = 1'b0;
      #1;
      checkOutput("release_in_ready", {31'b0, bus.in_ready}, 32'd1);

      // Streaming at full rate.
      bus.out_ready = 1'b1;
      pop_cycles.delete();
      applyStimulus(2'd0, 32'h11, 1'b0);
      checkOutput("latency_valid", {31'b0, bus.out_valid}, 32'd1);
      applyStimulus(2'd1, 32'h22, 1'b0);
      applyStimulus(2'd2, 32'h33, 1'b0);
      applyStimulus(2'd3, 32'h11, 1'b1);
      waitCycles(2);
      checkOutput("stream_pops", pop_cycles.size(), 32'd4);
      if (pop_cycles.size() == 4)
         checkOutput("stream_rate", pop_cycles[3] - pop_cycles[0], 32'd3);

      // Out-of-range select followed by an in-range one.
      applyStimulus(2'd3, 32'h11, 1'b1);
      applyStimulus(2'd1, 32'h22, 1'b0);
      waitCycles(2);

      // Back-pressure: A, B fill main and skid, C waits.
      bus.out_ready = 1'b0;
      applyStimulus(2'd1, 32'h22, 1'b0);
      applyStimulus(2'd2, 32'h33, 1'b0);
      checkOutput("full_in_ready", {31'b0, bus.in_ready}, 32'd0);
      checkOutput("full_out_data", bus.out_data, 32'h22);
      fork
         applyStimulus(2'd0, 32'h11, 1'b0);
         begin
            waitCycles(2);
            checkOutput("hold_out_data", bus.out_data, 32'h22);
            checkOutput("hold_out_sel", {30'b0, bus.out_sel}, 32'd1);
            bus.out_ready = 1'b1;
         end
      join
      waitCycles(3);
      checkOutput("bp_drained", exp_q.size(), 32'd0);

      // Simultaneous pop and accept as in_ready rises.
      bus.out_ready = 1'b0;
      applyStimulus(2'd0, 32'h11, 1'b0);
      applyStimulus(2'd1, 32'h22, 1'b0);
      fork
         begin
            applyStimulus(2'd2, 32'h33, 1'b0);
            applyStimulus(2'd3, 32'h11, 1'b1);
         end
         begin
            waitCycles(1);
            bus.out_ready = 1'b1;
         end
      join
      checkOutput("simul_in_ready", {31'b0, bus.in_ready}, 32'd1);
      waitCycles(3);

      // Flush with both registers full and a producer waiting.
      bus.out_ready = 1'b0;
      applyStimulus(2'd1, 32'h22, 1'b0);
      applyStimulus(2'd2, 32'h33, 1'b0);
      bus.flush    = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_sel   = 2'd0;
      waitCycles(1);
      bus.flush    = 1'b0;
      bus.in_valid = 1'b0;
      exp_q.delete();
      checkOutput("flush_out_valid", {31'b0, bus.out_valid}, 32'd0);
      checkOutput("flush_in_ready", {31'b0, bus.in_ready}, 32'd1);

      // Flush on an empty pipe discards the beat accepted the same cycle.
      bus.flush    = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_sel   = 2'd1;
      waitCycles(1);
      bus.flush    = 1'b0;
      bus.in_valid = 1'b0;
      checkOutput("flush_accept_dropped", {31'b0, bus.out_valid}, 32'd0);
      bus.out_ready = 1'b1;
      applyStimulus(2'd2, 32'h33, 1'b0);
      waitCycles(2);

      // Reset mid-transfer drops held beats.
      bus.out_ready = 1'b0;
      applyStimulus(2'd2, 32'h33, 1'b0);
      resetn = 1'b0;
      waitCycles(1);
      exp_q.delete();
      checkOutput("midreset_out_valid", {31'b0, bus.out_valid}, 32'd0);
      checkOutput("midreset_out_data", bus.out_data, 32'h0);
      resetn        = 1'b1;
      bus.out_ready = 1'b1;
      applyStimulus(2'd1, 32'h22, 1'b0);

      for (int i = 0; i < 20 && exp_q.size() != 0; i++) waitCycles(1);
      waitCycles(1);
      checkOutput("scoreboard_empty", exp_q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
